// File: rtl/DDR3cont_pkg.sv
// Shared DDR3 controller definitions: address geometry, host request
// record and the flat-address to row/bank/column split.
package DDR3cont_pkg;

    localparam int ADDR_MCTRL = 32;
    localparam int ROW_BITS   = 14;
    localparam int BA_BITS    = 3;
    localparam int COL_BITS   = 10;
    localparam int DQ_BITS    = 8;
    localparam int BURST_L    = 8;
    localparam int WDATA_BITS = BURST_L * DQ_BITS;
    localparam int QDEPTH     = 4;

    // Column offset bits covered by one BL8 burst; these are forced to zero.
    localparam int BURST_OFS  = $clog2(BURST_L);

    typedef struct packed {
        logic                  we;
        logic [ROW_BITS-1:0]   row;
        logic [BA_BITS-1:0]    bank;
        logic [COL_BITS-1:0]   col;
        logic [WDATA_BITS-1:0] wdata;
    } host_req_t;

    typedef struct packed {
        logic [ROW_BITS-1:0] row;
        logic [BA_BITS-1:0]  bank;
        logic [COL_BITS-1:0] col;
    } addr_fields_t;

    // Layout is {unused, row, bank, col}; the column is rounded down to a
    // burst boundary so the controller always issues aligned BL8 accesses.
    function automatic addr_fields_t addr_split(input logic [ADDR_MCTRL-1:0] addr);
        addr_fields_t f;
        f.col  = {addr[COL_BITS-1:BURST_OFS], {BURST_OFS{1'b0}}};
        f.bank = addr[COL_BITS +: BA_BITS];
        f.row  = addr[COL_BITS+BA_BITS +: ROW_BITS];
        return f;
    endfunction

endpackage

// File: rtl/ddr3_req_fifo.sv
// In-order FIFO of host requests whose head entry is held in an output
// register, so the consumer sees no combinational path from the producer.
module ddr3_req_fifo
    import DDR3cont_pkg::*;
#(
    parameter  int DEPTH = QDEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  host_req_t        push_data,
    output logic             full,
    input  logic             pop,
    output logic             head_valid,
    output host_req_t        head,
    output logic [CNT_W-1:0] count
);

    host_req_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] remaining;
    host_req_t        head_next;
    logic             do_push;
    logic             do_pop;

    // Full is taken from the occupancy count; pointer equality is ambiguous.
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = head_valid && pop;

    // Work out next occupancy and what the head register must show next cycle.
    // If the queue would otherwise be empty after a pop, the entry being pushed
    // right now becomes the head directly, since it is not yet in storage.
    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
        rd_next   = do_pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        remaining = do_pop ? count - CNT_W'(1) : count;
        head_next = head;
        if (count_next != '0) begin
            if (do_push && remaining == '0) begin
                head_next = push_data;
            end else begin
                head_next = mem[rd_next];
            end
        end
    end

    // Storage array has no reset; stale entries are never presented.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and the registered head; head holds when empty.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head       <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr     <= rd_next;
            count      <= count_next;
            head_valid <= (count_next != '0);
            head       <= head_next;
        end
    end

endmodule

// File: rtl/ddr3_host_cmd_queue.sv
// Host request front end for the DDR3 controller: splits each byte address
// into row/bank/column, queues requests in order and flags misalignment.
module ddr3_host_cmd_queue
    import DDR3cont_pkg::*;
#(
    parameter  int DEPTH = QDEPTH,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  host_valid,
    output logic                  host_ready,
    input  logic                  host_we,
    input  logic [ADDR_MCTRL-1:0] host_addr,
    input  logic [WDATA_BITS-1:0] host_wdata,
    output logic                  ctrl_valid,
    input  logic                  ctrl_ready,
    output logic                  ctrl_we,
    output logic [ROW_BITS-1:0]   ctrl_row,
    output logic [BA_BITS-1:0]    ctrl_bank,
    output logic [COL_BITS-1:0]   ctrl_col,
    output logic [WDATA_BITS-1:0] ctrl_wdata,
    output logic [CNT_W-1:0]      q_count,
    output logic                  align_err,
    input  logic                  align_err_clr
);

    addr_fields_t fields;
    host_req_t    req;
    host_req_t    head;
    logic         full;
    logic         push;
    logic         misaligned;

    // Build the queued record from the host request at the time of push.
    always_comb begin
        fields     = addr_split(host_addr);
        req.we     = host_we;
        req.row    = fields.row;
        req.bank   = fields.bank;
        req.col    = fields.col;
        req.wdata  = host_wdata;
        misaligned = (host_addr[BURST_OFS-1:0] != '0);
    end

    assign host_ready = !full;
    assign push       = host_valid && host_ready;

    ddr3_req_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (push),
        .push_data  (req),
        .full       (full),
        .pop        (ctrl_ready),
        .head_valid (ctrl_valid),
        .head       (head),
        .count      (q_count)
    );

    assign ctrl_we    = head.we;
    assign ctrl_row   = head.row;
    assign ctrl_bank  = head.bank;
    assign ctrl_col   = head.col;
    assign ctrl_wdata = head.wdata;

    // Sticky misalignment flag; a new misaligned push beats a clear request.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            align_err <= 1'b0;
        end else if (push && misaligned) begin
            align_err <= 1'b1;
        end else if (align_err_clr) begin
            align_err <= 1'b0;
        end
    end

endmodule

// File: doc/ddr3_host_cmd_queue.md
Name: ddr3_host_cmd_queue

Overview:
Host-side front end that sits directly upstream of the DDR3 memory controller FSM. It accepts read/write requests carrying a 32-bit byte address and a full BL8 write burst. Requests are buffered in a small in-order FIFO, and each flat address is split into row/bank/column fields. Requests are presented to the controller over a valid/ready handshake; one entry is consumed per controller ACTIVATE→READ/WRITE→AUTOPRE cycle.

Parameters:
DEPTH, 4, queue entries; power of two, minimum 2.
ADDR_MCTRL, 32, host address width (shared package).
ROW_BITS, 14, row field width (shared package).
BA_BITS, 3, bank field width (shared package).
COL_BITS, 10, column field width (shared package).
DQ_BITS, 8, data bits per beat (shared package).
BURST_L, 8, beats per burst; write data width is BURST_L*DQ_BITS = 64.

Ports:
clock  in  1  single clock; all state updates on the rising edge
reset_n  in  1  asynchronous, active-low reset
host_valid  in  1  host request present
host_ready  out  1  queue can accept; equals !full
host_we  in  1  1 = write, 0 = read
host_addr  in  32  byte address
host_wdata  in  64  write burst, beat 0 in [7:0]; ignored for reads
ctrl_valid  out  1  head entry valid toward the controller
ctrl_ready  in  1  controller takes the head entry (sampled only while it is in IDLE_WAIT)
ctrl_we  out  1  head entry type
ctrl_row  out  14  head row
ctrl_bank  out  3  head bank
ctrl_col  out  10  head column, always BL8-aligned
ctrl_wdata  out  64  head write data
q_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
align_err  out  1  sticky flag: a request was accepted with host_addr[2:0] != 0
align_err_clr  in  1  synchronous clear for align_err

Behaviour:
- Reset (async assert, sync deassert):
  - read/write pointers and q_count go to 0.
  - ctrl_valid=0, align_err=0, host_ready=1.
  - ctrl_we/row/bank/col/wdata=0.
  - Storage array is not cleared.
- Push: occurs when host_valid && host_ready. The entry is written at wr_ptr, then wr_ptr increments modulo DEPTH.
- Address split, applied at push:
  - col = {host_addr[9:3], 3'b000}
  - bank = host_addr[12:10]
  - row = host_addr[26:13]
  - host_addr[31:27] is ignored.
- Alignment: if host_addr[2:0] != 0 at push, align_err is set the next cycle and the entry is still accepted with the low bits dropped.
- align_err update rule: align_err_clr in the same cycle as a new misaligned push leaves align_err = 1 (set wins). Otherwise align_err_clr clears it.
- Pop: occurs when ctrl_valid && ctrl_ready. rd_ptr increments modulo DEPTH.
- Output registering:
  - ctrl_* outputs are registered copies of the head entry.
  - Push into an empty queue → ctrl_valid=1 on the next cycle (1-cycle latency, no combinational host→ctrl path).
  - After a pop, the next head is presented the following cycle with no bubble when q_count ≥ 2.
- ctrl_* fields hold stable while ctrl_valid=1 and ctrl_ready=0.
- q_count update: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- Full (q_count==DEPTH): host_ready=0, including the cycle of a pop. There is no full-bypass; a freed slot becomes visible the next cycle.
- Empty: ctrl_valid=0 and ctrl_* hold their last values. ctrl_ready while empty is ignored.
- Ordering: strictly FIFO. No read/write reordering and no bank merging.
- Pointer wrap: pointers are $clog2(DEPTH) bits. Full/empty are derived from q_count, not from pointer equality.
- Reset mid-operation: all queued requests are discarded and the outputs return to reset values within the same cycle reset_n falls.

Decomposition:
- Shared package (DDR3cont_pkg) additions:
  - QDEPTH constant.
  - Packed struct host_req_t {we, row[ROW_BITS], bank[BA_BITS], col[COL_BITS], wdata[BURST_L*DQ_BITS]}.
  - Function addr_split(ADDR_MCTRL-bit addr) returning row/bank/col.
- One sub-module, ddr3_req_fifo: a generic registered FIFO of host_req_t with occupancy count. The top level adds only the address split and the alignment flag.

Test Plan:
- Write host_addr=0x0000_2C08, wdata=0x0807_0605_0403_0201 into an empty queue → one cycle later ctrl_valid=1, ctrl_we=1, row=1, bank=3, col=0x008, wdata unchanged; align_err=0.
- Push 4 reads at addresses 0x0, 0x400, 0x800, 0xC00 with ctrl_ready=0 → q_count=4, host_ready=0; a 5th host_valid is not accepted; ctrl_* holds bank=0 throughout.
- From the full state, assert ctrl_ready for 4 cycles → banks 0,1,2,3 pop in order, one per cycle; host_ready=1 from the cycle after the first pop; q_count reaches 0 and ctrl_valid=0.
- At q_count=2, push and pop in the same cycle → q_count stays 2 and the popped and pushed entries keep FIFO order.
- Read at host_addr=0x0000_0005 → col=0x000, align_err=1 sticky; align_err_clr pulse → 0; clear coincident with a misaligned push → stays 1.
- Assert reset_n=0 with 3 entries queued → q_count=0, ctrl_valid=0, host_ready=1 immediately; after release the next push appears with 1-cycle latency.
